// File: rtl/mem_access_ctrl.sv
// Multi-cycle load/store controller between the MEM stage and memory_block.
// Registers one request, holds the memory strobe for WAIT_CYCLES cycles, then returns a one-cycle response.
module mem_access_ctrl #(
  parameter int ADDR_W      = 18,
  parameter int DATA_W      = 32,
  parameter int WAIT_CYCLES = 1   // legal range 1..15
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic              req_byte,
  input  logic              req_signed,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_error,
  output logic              busy,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_write_data,
  output logic              mem_read,
  output logic              mem_write,
  output logic              mem_byte_ops,
  input  logic [DATA_W-1:0] mem_read_data
);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_e;

  localparam logic [3:0] CNT_INIT = 4'(WAIT_CYCLES - 1);

  state_e              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic                write_q, write_d;
  logic                byte_q, byte_d;
  logic                signed_q, signed_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                error_q, error_d;
  logic [DATA_W-1:0]   load_result;

  always_comb begin
    if (!byte_q)
      load_result = mem_read_data;
    else if (signed_q)
      load_result = {{(DATA_W-8){mem_read_data[7]}}, mem_read_data[7:0]};
    else
      load_result = {{(DATA_W-8){1'b0}}, mem_read_data[7:0]};
  end

  always_comb begin
    // NOTE: every signal gets a hold-value default first so no path through the case infers a latch.
    state_d  = state_q;
    cnt_d    = cnt_q;
    write_d  = write_q;
    byte_d   = byte_q;
    signed_d = signed_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    error_d  = error_q;

    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          write_d  = req_write;
          byte_d   = req_byte;
          signed_d = req_signed;
          addr_d   = req_addr;
          // Byte stores present only the low byte so memory_block never sees stale upper bits.
          wdata_d  = req_byte ? {{(DATA_W-8){1'b0}}, req_wdata[7:0]} : req_wdata;
          if (!req_byte && (req_addr[1:0] != 2'b00)) begin
            state_d = RESP;
            error_d = 1'b1;
            rdata_d = '0;
          end else begin
            state_d = ACCESS;
            cnt_d   = CNT_INIT;
          end
        end
      end
      ACCESS: begin
        if (cnt_q == 4'd0) begin
          state_d = RESP;
          error_d = 1'b0;
          rdata_d = write_q ? '0 : load_result;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      write_q  <= 1'b0;
      byte_q   <= 1'b0;
      signed_q <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      error_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge values of the others.
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      write_q  <= write_d;
      byte_q   <= byte_d;
      signed_q <= signed_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      error_q  <= error_d;
    end
  end

  // Strobes decode straight from the state register, so an async reset drops them immediately.
  assign req_ready      = (state_q == IDLE);
  assign busy           = (state_q == ACCESS) || (state_q == RESP);
  assign resp_valid     = (state_q == RESP);
  assign resp_rdata     = rdata_q;
  assign resp_error     = error_q;
  assign mem_address    = addr_q;
  assign mem_write_data = wdata_q;
  assign mem_byte_ops   = byte_q;
  assign mem_read       = (state_q == ACCESS) && !write_q;
  assign mem_write      = (state_q == ACCESS) && write_q;

endmodule
